// File: rtl/trace_pkg.sv
// Shared types for the retirement trace unit: opcode constants, FSM states, trace record layout
// and the instruction classifier used by the performance counters.
package trace_pkg;

  // Records are sized for RV64; narrower datapaths are zero-extended into them.
  localparam int unsigned TraceXlen = 64;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } trace_state_e;

  typedef enum logic [1:0] {
    ClsNone,
    ClsAlu,
    ClsMem,
    ClsBranch
  } insn_class_e;

  typedef struct packed {
    logic [TraceXlen-1:0] pc;
    logic [31:0]          insn;
    logic [4:0]           rd;
    logic                 wen;
    logic [TraceXlen-1:0] wdata;
  } trace_rec_t;

  function automatic insn_class_e classify(input logic [6:0] opcode);
    insn_class_e cls;
    case (opcode)
      OP_R, OP_IMM:      cls = ClsAlu;
      OP_LOAD, OP_STORE: cls = ClsMem;
      OP_BRANCH:         cls = ClsBranch;
      default:           cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head, so the head record and its
// valid flag come straight from flops.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty && !clear;
  // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
  assign do_push = push && (!full || do_pop) && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
    // Preload the slot the next read pointer names, bypassing a write that becomes the head.
    if (clear) begin
      head_d = '0;
    end else if (!valid_d) begin
      head_d = head_q;
    end else if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_valid = valid_q;
  assign head_data  = head_q;

endmodule

// File: rtl/retire_trace_unit.sv
// Retirement monitor: run/drain/done FSM, opcode classifier, saturating performance counters
// and a trace FIFO drained over a valid/ready port.
module retire_trace_unit
  import trace_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] HALT_INSN = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [31:0]      retire_insn,
  input  logic [4:0]       retire_rd,
  input  logic             retire_wen,
  input  logic [XLEN-1:0]  retire_wdata,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [XLEN-1:0]  trace_pc,
  output logic [31:0]      trace_insn,
  output logic [4:0]       trace_rd,
  output logic             trace_wen,
  output logic [XLEN-1:0]  trace_wdata,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] alu_count,
  output logic [CNT_W-1:0] mem_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             halted
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] alu_q, alu_d;
  logic [CNT_W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0] branch_q, branch_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             halted_q, halted_d;

  trace_rec_t  push_rec, head_rec;
  insn_class_e insn_class;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, head_valid;
  logic        active, is_halt, accept, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CntMax)) ? v + CNT_W'(1) : v;
  endfunction

  assign is_halt    = (retire_insn == HALT_INSN);
  assign insn_class = classify(retire_insn[6:0]);
  // The first retirement seen in IDLE is handled exactly like one in RUN.
  assign active     = (state_q == StRun) || ((state_q == StIdle) && retire_valid);
  assign accept     = active && retire_valid && !is_halt;
  assign fifo_pop   = head_valid && trace_ready;
  assign fifo_push  = accept && !clear;
  assign drop       = accept && fifo_full && !fifo_pop;

  always_comb begin
    push_rec       = '0;
    push_rec.pc    = TraceXlen'(retire_pc);
    push_rec.insn  = retire_insn;
    push_rec.rd    = retire_rd;
    push_rec.wen   = retire_wen;
    push_rec.wdata = retire_wen ? TraceXlen'(retire_wdata) : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (retire_valid) state_d = is_halt ? StDrain : StRun;
      StRun:   if (retire_valid && is_halt) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StDone;
    endcase

    cycle_d  = sat_inc(cycle_q, active);
    retire_d = sat_inc(retire_q, accept);
    alu_d    = sat_inc(alu_q, accept && (insn_class == ClsAlu));
    mem_d    = sat_inc(mem_q, accept && (insn_class == ClsMem));
    branch_d = sat_inc(branch_q, accept && (insn_class == ClsBranch));
    drop_d   = sat_inc(drop_q, drop);

    if (clear) begin
      state_d  = StIdle;
      cycle_d  = '0;
      retire_d = '0;
      alu_d    = '0;
      mem_d    = '0;
      branch_d = '0;
      drop_d   = '0;
    end
    halted_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cycle_q  <= '0;
      retire_q <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      branch_q <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      branch_q <= branch_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (fifo_push),
    .push_data  (push_rec),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_data  (head_rec)
  );

  assign trace_valid  = head_valid;
  assign trace_pc     = head_rec.pc[XLEN-1:0];
  assign trace_insn   = head_rec.insn;
  assign trace_rd     = head_rec.rd;
  assign trace_wen    = head_rec.wen;
  assign trace_wdata  = head_rec.wdata[XLEN-1:0];
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign alu_count    = alu_q;
  assign mem_count    = mem_q;
  assign branch_count = branch_q;
  assign drop_count   = drop_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Scoreboard bench: expected trace records are queued at issue time and a negedge monitor
// checks every handshake; counters and halt timing are checked against hand-computed values.
module tb_retire_trace_unit;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        retire_valid = 1'b0;
  logic        s_valid = 1'b0;
  logic [63:0] retire_pc = '0;
  logic [31:0] retire_insn = '0;
  logic [4:0]  retire_rd = '0;
  logic        retire_wen = 1'b0;
  logic [63:0] retire_wdata = '0;
  logic        trace_ready = 1'b0;

  logic        trace_valid, trace_wen, halted;
  logic [63:0] trace_pc, trace_wdata;
  logic [31:0] trace_insn;
  logic [4:0]  trace_rd;
  logic [31:0] cycle_count, retire_count, alu_count, mem_count, branch_count, drop_count;

  logic        s_tvalid, s_twen, s_halted;
  logic [63:0] s_tpc, s_twdata;
  logic [31:0] s_tinsn;
  logic [4:0]  s_trd;
  logic [3:0]  s_cycle, s_retire, s_alu, s_mem, s_branch, s_drop;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pops = 0;

  always #5 clk = ~clk;

  retire_trace_unit dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_insn  (retire_insn),
    .retire_rd    (retire_rd),
    .retire_wen   (retire_wen),
    .retire_wdata (retire_wdata),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_insn   (trace_insn),
    .trace_rd     (trace_rd),
    .trace_wen    (trace_wen),
    .trace_wdata  (trace_wdata),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .alu_count    (alu_count),
    .mem_count    (mem_count),
    .branch_count (branch_count),
    .drop_count   (drop_count),
    .halted       (halted)
  );

  retire_trace_unit #(.CNT_W(4)) dut_small (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .retire_valid (s_valid),
    .retire_pc    (retire_pc),
    .retire_insn  (retire_insn),
    .retire_rd    (retire_rd),
    .retire_wen   (retire_wen),
    .retire_wdata (retire_wdata),
    .trace_valid  (s_tvalid),
    .trace_ready  (1'b1),
    .trace_pc     (s_tpc),
    .trace_insn   (s_tinsn),
    .trace_rd     (s_trd),
    .trace_wen    (s_twen),
    .trace_wdata  (s_twdata),
    .cycle_count  (s_cycle),
    .retire_count (s_retire),
    .alu_count    (s_alu),
    .mem_count    (s_mem),
    .branch_count (s_branch),
    .drop_count   (s_drop),
    .halted       (s_halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic wen, input logic [63:0] wd, input logic [63:0] exp_wd,
                        input bit exp_push);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_insn  = insn;
    retire_rd    = rd;
    retire_wen   = wen;
    retire_wdata = wd;
    if (exp_push) exp_q.push_back('{pc, insn, rd, wen, exp_wd});
    step();
    retire_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    pops = 0;
  endtask

  // Every accepted handshake must present the oldest outstanding expected record.
  always @(negedge clk) begin
    if (reset && !clear && trace_valid && trace_ready) begin
      pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trace_pop: got record pc 0x%0h, expected no record", trace_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (trace_pc !== mon_e.pc || trace_insn !== mon_e.insn || trace_rd !== mon_e.rd ||
            trace_wen !== mon_e.wen || trace_wdata !== mon_e.wdata) begin
          n_fail++;
          $display("FAIL trace_rec: got pc=%0h insn=%0h rd=%0d wen=%0b wd=%0h, expected pc=%0h insn=%0h rd=%0d wen=%0b wd=%0h",
                   trace_pc, trace_insn, trace_rd, trace_wen, trace_wdata,
                   mon_e.pc, mon_e.insn, mon_e.rd, mon_e.wen, mon_e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    step();
    step();
    reset = 1'b1;
    step();
    check("rst_cycle", cycle_count, 0);
    check("rst_retire", retire_count, 0);
    check("rst_tvalid", trace_valid, 0);
    check("rst_tpc", trace_pc, 0);
    check("rst_twdata", trace_wdata, 0);
    check("rst_halted", halted, 0);

    // Mixed program then halt, sink always ready
    trace_ready = 1'b1;
    retire(64'h0,  32'h01400513, 5'd10, 1'b1, 64'h14,   64'h14, 1'b1);
    retire(64'hC,  32'h00B00633, 5'd12, 1'b1, 64'h28,   64'h28, 1'b1);
    retire(64'h10, 32'h00C13023, 5'd0,  1'b0, 64'hDEAD, 64'h0,  1'b1);
    retire(64'h14, 32'h00C50463, 5'd0,  1'b0, 64'h0,    64'h0,  1'b1);
    retire(64'h18, 32'h00000000, 5'd0,  1'b0, 64'h0,    64'h0,  1'b0);
    check("t1_halted_drain", halted, 0);
    step();
    check("t1_halted_done", halted, 1);
    check("t1_retire", retire_count, 4);
    check("t1_alu", alu_count, 2);
    check("t1_mem", mem_count, 1);
    check("t1_branch", branch_count, 1);
    check("t1_cycle", cycle_count, 5);
    check("t1_pops", pops, 4);
    retire(64'h40, 32'h00100093, 5'd1, 1'b1, 64'h1, 64'h1, 1'b0);
    check("t1_done_ignored", retire_count, 4);
    check("t1_done_empty", trace_valid, 0);

    // Overflow with a stalled sink
    trace_ready = 1'b0;
    do_clear();
    check("clr_retire", retire_count, 0);
    check("clr_halted", halted, 0);
    for (int i = 0; i < 20; i++) begin
      retire(64'h100 + 64'(4 * i), 32'h00100093, 5'd1, 1'b1, 64'(i), 64'(i), i < 16);
    end
    check("t2_drop", drop_count, 4);
    check("t2_retire", retire_count, 20);
    check("t2_alu", alu_count, 20);
    check("t2_cycle", cycle_count, 20);
    check("t2_tvalid", trace_valid, 1);
    check("t2_first_pc", trace_pc, 64'h100);
    step();
    step();
    step();
    check("t2_hold_pc", trace_pc, 64'h100);
    check("t2_hold_wd", trace_wdata, 0);

    // Full FIFO with simultaneous push and pop every cycle
    trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      retire(64'h200 + 64'(4 * i), 32'h00B00633, 5'd12, 1'b1, 64'h1000 + 64'(i),
             64'h1000 + 64'(i), 1'b1);
    end
    check("t3_drop", drop_count, 4);
    check("t3_retire", retire_count, 30);
    for (int k = 0; k < 40 && trace_valid; k++) step();
    check("t3_drained", trace_valid, 0);
    check("t3_pops", pops, 26);

    // Halt with three records buffered, sink stalled, retirements during drain
    trace_ready = 1'b0;
    do_clear();
    retire(64'h300, 32'h0000A103, 5'd2, 1'b1, 64'h77, 64'h77, 1'b1);
    retire(64'h304, 32'h00208463, 5'd0, 1'b0, 64'h5,  64'h0,  1'b1);
    retire(64'h308, 32'h00100093, 5'd1, 1'b1, 64'h9,  64'h9,  1'b1);
    retire(64'h30C, 32'h00000000, 5'd0, 1'b0, 64'h0,  64'h0,  1'b0);
    retire(64'h310, 32'h00100093, 5'd1, 1'b1, 64'hA,  64'hA,  1'b0);
    retire(64'h314, 32'h00B00633, 5'd3, 1'b1, 64'hB,  64'hB,  1'b0);
    step();
    step();
    step();
    check("t4_halted_stall", halted, 0);
    check("t4_retire", retire_count, 3);
    check("t4_alu", alu_count, 1);
    check("t4_mem", mem_count, 1);
    check("t4_branch", branch_count, 1);
    check("t4_cycle", cycle_count, 4);
    trace_ready = 1'b1;
    step();
    step();
    step();
    check("t4_halted_third_pop", halted, 0);
    step();
    check("t4_halted", halted, 1);
    check("t4_pops", pops, 3);

    // Asynchronous reset mid-stream, then clear with the same backlog
    trace_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      retire(64'h400 + 64'(4 * i), 32'h00100093, 5'd4, 1'b1, 64'h50, 64'h50, 1'b1);
    end
    check("t5_backlog", trace_valid, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_tvalid", trace_valid, 0);
    check("t5_rst_tpc", trace_pc, 0);
    check("t5_rst_retire", retire_count, 0);
    check("t5_rst_cycle", cycle_count, 0);
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire(64'h500 + 64'(4 * i), 32'h00100093, 5'd4, 1'b1, 64'h60, 64'h60, 1'b1);
    end
    do_clear();
    check("t5_clr_tvalid", trace_valid, 0);
    check("t5_clr_tpc", trace_pc, 0);
    check("t5_clr_retire", retire_count, 0);
    check("t5_clr_cycle", cycle_count, 0);
    check("t5_clr_halted", halted, 0);

    // Saturation on the 4-bit counter instance
    retire_insn = 32'h00100093;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    s_valid = 1'b0;
    step();
    check("t6_retire_sat", s_retire, 15);
    check("t6_cycle_sat", s_cycle, 15);
    check("t6_alu_sat", s_alu, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_unit.md
# retire_trace_unit

Synthesizable retirement monitor for the sequential RV64 core, replacing simulation-only per-cycle printing and cycle counting. It observes one retired instruction per cycle, keeps saturating performance counters (cycles, retired, per-class), buffers a trace record per retirement in a parametrised FIFO drained over a valid/ready port, and detects the halt instruction. Sits beside `cpu_sequential`, fed from its writeback stage; the trace port goes to a debug/log sink.

## Interface
- `XLEN`, 64, datapath width of PC and write data
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2
- `CNT_W`, 32, width of every counter
- `HALT_INSN`, 32'h0000_0000, encoding treated as halt

- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-low
- `clear` in 1: synchronous clear of counters, FIFO and FSM
- `retire_valid` in 1: an instruction retires this cycle
- `retire_pc` in XLEN: PC of retiring instruction
- `retire_insn` in 32: instruction word
- `retire_rd` in 5: destination register
- `retire_wen` in 1: register write performed
- `retire_wdata` in XLEN: value written
- `trace_valid` out 1: trace head valid
- `trace_ready` in 1: sink accepts head
- `trace_pc` out XLEN, `trace_insn` out 32, `trace_rd` out 5, `trace_wen` out 1, `trace_wdata` out XLEN: head record
- `cycle_count`, `retire_count`, `alu_count`, `mem_count`, `branch_count`, `drop_count` out CNT_W each
- `halted` out 1: halt seen and FIFO drained

## Operation
- FSM states IDLE, RUN, DRAIN, DONE. Reset/clear → IDLE.
- IDLE: `retire_valid`=1 → RUN; that retirement is processed in the same cycle as in RUN.
- RUN: each cycle `cycle_count`+1. On `retire_valid` with `retire_insn`≠HALT_INSN: `retire_count`+1; class counter +1 by opcode [6:0]: 0110011/0010011 → alu, 0000011/0100011 → mem, 1100011 → branch, other → none; push record.
- RUN, `retire_valid` with HALT_INSN: `cycle_count`+1, no retire count, no push, → DRAIN.
- DRAIN: no counting; retirements ignored. FIFO occupancy 0 → DONE.
- DONE: `halted`=1; retirements ignored; FIFO stays empty; only reset/clear leave.
- Push when full: accepted only if a pop completes same cycle (occupancy unchanged); otherwise record dropped, `drop_count`+1.
- Pop: `trace_valid`&&`trace_ready`. Pop on empty impossible (`trace_valid`=0).
- `trace_wdata` = `retire_wdata` when `retire_wen`=1, else 0.
- All counters saturate at all-ones, never wrap.
- FIFO pointers log2(DEPTH) bits plus wrap bit; full/empty from pointer compare.
- `clear` overrides every other event that cycle; a pop handshake in the clear cycle is discarded with the FIFO.
- Reset mid-operation: asynchronous, everything back to reset values immediately.

## Timing
- Reset values: all counters 0, `trace_valid`=0, trace data outputs 0, `halted`=0, state IDLE, FIFO empty.
- All outputs registered. Counter increments visible the cycle after the retire cycle.
- Push at edge N into empty FIFO → `trace_valid`=1 from cycle N+1.
- `trace_*` data held stable while `trace_valid`=1 and `trace_ready`=0.
- Halt retired at edge N with FIFO empty → DRAIN after N, DONE after N+1, `halted`=1 from cycle N+2.
- Full throughput: one push and one pop per cycle sustained.

## Structure
- Package `trace_pkg`: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), FSM state enum, `trace_rec_t` struct {pc, insn, rd, wen, wdata}.
- Sub-module `trace_fifo`: synchronous FIFO parametrised in DEPTH and record width, push/pop/full/empty/registered head. Top holds FSM, classifier and counters.

## Test plan
- Reset, then addi (0x01400513) at pc 0, add (0x00B00633) at pc 0xC, sd, beq, then 0x0 → `retire_count`=4, `alu_count`=2, `mem_count`=1, `branch_count`=1, `halted`=1 two cycles after FIFO empties.
- `trace_ready`=0, 20 retirements, DEPTH=16 → 16 records, `drop_count`=4; then ready=1 → records pop in order, first pc matches first retirement.
- FIFO full, `trace_ready`=1, continuous retirements → no drops, occupancy stays 16.
- CNT_W=4, 20 retirements → `retire_count`=15, `cycle_count` stuck at 15.
- Halt with 3 buffered records, `trace_ready`=0 for 5 cycles → `halted`=0 until third pop, retirements during DRAIN not counted.
- Assert `reset`=0 mid-stream with FIFO holding 5 → outputs 0 immediately; `clear` pulse → same state one edge later.
